// File: rtl/chess_bus_pkg.sv
// chess_bus_pkg: shared bus widths, arbiter state encoding and index-width helper
// for the move-generator memory arbiter.
package chess_bus_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_DRAIN} arb_state_t;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/move_gen_mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin choice of the first request after i_last, wrapping.
module rr_picker
   import chess_bus_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]        i_req,
   input  logic [idx_w(N_REQ)-1:0] i_last,
   output logic                    o_valid,
   output logic [idx_w(N_REQ)-1:0] o_idx
);
   localparam int IW = idx_w(N_REQ);
   logic [IW-1:0] w_j;
   // Scan from the farthest candidate down so the nearest request after i_last wins.
   always_comb begin
      o_idx = i_last;
      w_j = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_j = IW'((int'(i_last) + k) % N_REQ);
         if (i_req[w_j]) o_idx = w_j;
      end
   end
   assign o_valid = |i_req;
endmodule

// File: rtl/move_gen_mem_arbiter.sv
// move_gen_mem_arbiter: round-robin sharing of one SDRAM Avalon-MM master among N_REQ engines.
// Define MOVE_GEN_ARB_LOCK_EN to let req_lock hold the grant across owner idle gaps.
module move_gen_mem_arbiter
   import chess_bus_pkg::*;
#(
   parameter int N_REQ           = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ*ADDR_W-1:0] req_address,
   input  logic [N_REQ-1:0]        req_read,
   input  logic [N_REQ-1:0]        req_write,
   input  logic [N_REQ*DATA_W-1:0] req_writedata,
   input  logic [N_REQ-1:0]        req_lock,
   output logic [N_REQ-1:0]        req_waitrequest,
   output logic [DATA_W-1:0]       req_readdata,
   output logic [N_REQ-1:0]        req_readdatavalid,
   input  logic                    master_waitrequest,
   output logic [ADDR_W-1:0]       master_address,
   output logic                    master_read,
   input  logic [DATA_W-1:0]       master_readdata,
   input  logic                    master_readdatavalid,
   output logic                    master_write,
   output logic [DATA_W-1:0]       master_writedata
);
   localparam int IW = idx_w(N_REQ);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   arb_state_t        r_state, w_state_next;
   logic [IW-1:0]     r_owner, r_last, w_pick;
   logic [CW-1:0]     r_count, w_count_next;
   logic              w_pick_valid, w_grant, w_full, w_inc, w_dec, w_lock;
   logic [N_REQ-1:0]  w_active;
   logic [ADDR_W-1:0] w_addr  [N_REQ];
   logic [DATA_W-1:0] w_wdata [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_slice
      assign w_addr[g]  = req_address[ADDR_W*g +: ADDR_W];
      assign w_wdata[g] = req_writedata[DATA_W*g +: DATA_W];
   end

   assign w_active = req_read | req_write;

   rr_picker #(.N_REQ(N_REQ)) u_picker (
      .i_req   (w_active),
      .i_last  (r_last),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick)
   );

`ifdef MOVE_GEN_ARB_LOCK_EN
   assign w_lock = req_lock[r_owner];
`else
   logic w_unused_lock;
   assign w_unused_lock = ^req_lock;
   assign w_lock = 1'b0;
`endif

   assign w_grant = (r_state == ARB_GRANT);
   // A return in the same cycle frees a slot, so the owner may issue one more read.
   assign w_full  = (r_count == CW'(MAX_OUTSTANDING)) & ~master_readdatavalid;
   assign w_inc   = master_read & ~master_waitrequest;
   assign w_dec   = master_readdatavalid;
   assign w_count_next = (w_inc & ~w_dec) ? r_count + 1'b1 :
                         (~w_inc & w_dec & (r_count != '0)) ? r_count - 1'b1 : r_count;
   assign req_readdata = master_readdata;

   always_comb begin
      master_address             = w_grant ? w_addr[r_owner] : '0;
      master_writedata           = w_grant ? w_wdata[r_owner] : '0;
      master_read                = w_grant & req_read[r_owner] & ~w_full;
      master_write               = w_grant & req_write[r_owner];
      req_waitrequest            = '1;
      req_waitrequest[r_owner]   = ~w_grant | master_waitrequest | w_full;
      req_readdatavalid          = '0;
      req_readdatavalid[r_owner] = (r_state != ARB_IDLE) & master_readdatavalid;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ARB_IDLE:  if (w_pick_valid) w_state_next = ARB_GRANT;
         ARB_GRANT: if (!w_active[r_owner] && !w_lock)
                       w_state_next = (w_count_next == '0) ? ARB_IDLE : ARB_DRAIN;
         ARB_DRAIN: if (w_count_next == '0) w_state_next = ARB_IDLE;
         default:   w_state_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ARB_IDLE;
         r_owner <= '0;
         r_last  <= IW'(N_REQ - 1);
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         if (r_state == ARB_IDLE && w_pick_valid) begin
            r_owner <= w_pick;
            r_last  <= w_pick;
         end
      end
   end
endmodule

// File: tb/tb_move_gen_mem_arbiter.sv
// tb_move_gen_mem_arbiter: directed scenarios plus a randomized run against a queue-based
// reference model of the round-robin memory arbiter.
module tb_move_gen_mem_arbiter;
   localparam int N  = 4;
   localparam int MO = 4;
`ifdef MOVE_GEN_ARB_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic            clk = 1'b0, rst_n = 1'b0;
   logic [N*32-1:0] req_address = '0, req_writedata = '0;
   logic [N-1:0]    req_read = '0, req_write = '0, req_lock = '0;
   logic [N-1:0]    req_waitrequest, req_readdatavalid;
   logic [31:0]     req_readdata;
   logic            master_waitrequest = 1'b0, master_readdatavalid = 1'b0;
   logic [31:0]     master_readdata = '0;
   logic [31:0]     master_address, master_writedata;
   logic            master_read, master_write;
   int              checks = 0, fails = 0;

   always #5 clk = ~clk;

   move_gen_mem_arbiter #(.N_REQ(N), .MAX_OUTSTANDING(MO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_address(req_address), .req_read(req_read), .req_write(req_write),
      .req_writedata(req_writedata), .req_lock(req_lock),
      .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
      .req_readdatavalid(req_readdatavalid),
      .master_waitrequest(master_waitrequest), .master_address(master_address),
      .master_read(master_read), .master_readdata(master_readdata),
      .master_readdatavalid(master_readdatavalid), .master_write(master_write),
      .master_writedata(master_writedata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_address = '0; req_writedata = '0; req_read = '0; req_write = '0; req_lock = '0;
      master_waitrequest = 1'b0; master_readdatavalid = 1'b0; master_readdata = '0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      req_read = '1;
      req_address = {N{32'h1234_5678}};
      @(negedge clk);
      checks++; if (master_read !== 1'b0) begin fails++; $display("FAIL rst_in_mread: got %b want 0", master_read); end
      checks++; if (req_waitrequest !== 4'hF) begin fails++; $display("FAIL rst_in_wait: got %b want 1111", req_waitrequest); end
      do_reset();
      @(negedge clk);
      checks++; if (req_waitrequest !== 4'hF) begin fails++; $display("FAIL rst_wait: got %b want 1111", req_waitrequest); end
      checks++; if (req_readdatavalid !== 4'h0) begin fails++; $display("FAIL rst_rdv: got %b want 0000", req_readdatavalid); end
      checks++; if ({master_read, master_write} !== 2'b00) begin fails++; $display("FAIL rst_rw: got %b want 00", {master_read, master_write}); end
      checks++; if ({master_address, master_writedata} !== 64'h0) begin fails++; $display("FAIL rst_bus: got %h want 0", {master_address, master_writedata}); end
   endtask

   task automatic test_single_read();
      do_reset();
      req_address[31:0] = 32'h100;
      req_read[0] = 1'b1;
      @(negedge clk);
      checks++; if (master_read !== 1'b0) begin fails++; $display("FAIL sr_latency: got %b want 0", master_read); end
      tick();
      @(negedge clk);
      checks++; if (master_address !== 32'h100) begin fails++; $display("FAIL sr_addr: got %h want 100", master_address); end
      checks++; if (master_read !== 1'b1) begin fails++; $display("FAIL sr_mread: got %b want 1", master_read); end
      checks++; if (req_waitrequest !== 4'b1110) begin fails++; $display("FAIL sr_wait: got %b want 1110", req_waitrequest); end
      tick();
      req_read[0] = 1'b0;
      tick(); tick();
      master_readdatavalid = 1'b1;
      master_readdata = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if (req_readdatavalid !== 4'b0001) begin fails++; $display("FAIL sr_rdv: got %b want 0001", req_readdatavalid); end
      checks++; if (req_readdata !== 32'hDEADBEEF) begin fails++; $display("FAIL sr_data: got %h want deadbeef", req_readdata); end
      tick();
      master_readdatavalid = 1'b0;
      @(negedge clk);
      checks++; if (req_readdatavalid !== 4'b0000) begin fails++; $display("FAIL sr_rdv_end: got %b want 0000", req_readdatavalid); end
   endtask

   task automatic test_round_robin();
      int order[$];
      int exp_ord[4] = '{0, 1, 3, 0};
      int eng[3] = '{0, 1, 3};
      bit drop[N];
      int acc = -1;
      do_reset();
      for (int i = 0; i < N; i++) drop[i] = 1'b0;
      for (int c = 0; c < 40 && order.size() < 4; c++) begin
         foreach (eng[e]) begin
            req_read[eng[e]] = !drop[eng[e]];
            drop[eng[e]] = 1'b0;
         end
         master_readdatavalid = (acc >= 0);
         @(negedge clk);
         if (acc >= 0) begin
            checks++; if (req_readdatavalid !== N'(1 << acc)) begin fails++; $display("FAIL rr_route: got %b want engine %0d", req_readdatavalid, acc); end
         end
         acc = -1;
         if (master_read && !master_waitrequest)
            for (int e = 0; e < N; e++)
               if (!req_waitrequest[e]) begin acc = e; order.push_back(e); drop[e] = 1'b1; end
         tick();
      end
      req_read = '0;
      master_readdatavalid = 1'b0;
      checks++; if (order.size() != 4) begin fails++; $display("FAIL rr_count: got %0d grants want 4", order.size()); end
      for (int i = 0; i < 4 && i < order.size(); i++) begin
         checks++; if (order[i] != exp_ord[i]) begin fails++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], exp_ord[i]); end
      end
   endtask

   task automatic test_outstanding_limit();
      int acc = 0;
      do_reset();
      req_read[2] = 1'b1;
      tick();
      repeat (6) begin
         @(negedge clk);
         if (master_read && !req_waitrequest[2]) acc++;
         tick();
      end
      checks++; if (acc != MO) begin fails++; $display("FAIL ol_accepted: got %0d want %0d", acc, MO); end
      @(negedge clk);
      checks++; if (master_read !== 1'b0) begin fails++; $display("FAIL ol_full_mread: got %b want 0", master_read); end
      checks++; if (req_waitrequest[2] !== 1'b1) begin fails++; $display("FAIL ol_full_wait: got %b want 1", req_waitrequest[2]); end
      tick();
      master_readdatavalid = 1'b1;
      @(negedge clk);
      checks++; if (master_read !== 1'b1) begin fails++; $display("FAIL ol_free_mread: got %b want 1", master_read); end
      checks++; if (req_waitrequest[2] !== 1'b0) begin fails++; $display("FAIL ol_free_wait: got %b want 0", req_waitrequest[2]); end
      checks++; if (req_readdatavalid !== 4'b0100) begin fails++; $display("FAIL ol_rdv: got %b want 0100", req_readdatavalid); end
      tick();
      req_read = '0;
      repeat (4) tick();
      master_readdatavalid = 1'b0;
      @(negedge clk);
      checks++; if (req_waitrequest !== 4'hF) begin fails++; $display("FAIL ol_idle_wait: got %b want 1111", req_waitrequest); end
   endtask

   task automatic test_drain_switch();
      do_reset();
      req_address[95:64] = 32'h2000;
      req_read[1] = 1'b1;
      req_read[2] = 1'b1;
      tick(); tick(); tick();
      req_read[1] = 1'b0;
      @(negedge clk);
      checks++; if (req_waitrequest !== 4'b1101) begin fails++; $display("FAIL ds_exit_wait: got %b want 1101", req_waitrequest); end
      tick();
      master_readdatavalid = 1'b1;
      @(negedge clk);
      checks++; if (req_waitrequest !== 4'hF) begin fails++; $display("FAIL ds_drain_wait: got %b want 1111", req_waitrequest); end
      checks++; if (req_readdatavalid !== 4'b0010) begin fails++; $display("FAIL ds_rdv1: got %b want 0010", req_readdatavalid); end
      tick();
      @(negedge clk);
      checks++; if (req_readdatavalid !== 4'b0010) begin fails++; $display("FAIL ds_rdv2: got %b want 0010", req_readdatavalid); end
      tick();
      master_readdatavalid = 1'b0;
      @(negedge clk);
      checks++; if (req_waitrequest !== 4'hF || master_read !== 1'b0) begin fails++; $display("FAIL ds_idle: got wait %b read %b want 1111/0", req_waitrequest, master_read); end
      tick();
      @(negedge clk);
      checks++; if (req_waitrequest !== 4'b1011) begin fails++; $display("FAIL ds_grant2: got %b want 1011", req_waitrequest); end
      checks++; if (master_address !== 32'h2000 || master_read !== 1'b1) begin fails++; $display("FAIL ds_fwd2: got %h/%b want 2000/1", master_address, master_read); end
   endtask

   task automatic test_lock();
      do_reset();
      req_write[0] = 1'b1;
      req_lock[0] = 1'b1;
      req_write[1] = 1'b1;
      tick();
      @(negedge clk);
      checks++; if (master_write !== 1'b1 || req_waitrequest !== 4'b1110) begin fails++; $display("FAIL lk_grant0: got %b/%b want 1/1110", master_write, req_waitrequest); end
      tick();
      req_write[0] = 1'b0;
      @(negedge clk);
      checks++; if (req_waitrequest !== 4'b1110) begin fails++; $display("FAIL lk_idle1: got %b want 1110", req_waitrequest); end
      tick();
      @(negedge clk);
      checks++; if (req_waitrequest !== (LOCK ? 4'b1110 : 4'b1111)) begin fails++; $display("FAIL lk_idle2: got %b want %b", req_waitrequest, LOCK ? 4'b1110 : 4'b1111); end
      tick();
      @(negedge clk);
      checks++; if (req_waitrequest !== (LOCK ? 4'b1110 : 4'b1101)) begin fails++; $display("FAIL lk_idle3: got %b want %b", req_waitrequest, LOCK ? 4'b1110 : 4'b1101); end
      checks++; if (master_write !== !LOCK) begin fails++; $display("FAIL lk_mwrite: got %b want %b", master_write, !LOCK); end
      tick();
      req_lock[0] = 1'b0;
      tick(); tick();
      @(negedge clk);
      checks++; if (req_waitrequest !== 4'b1101 || master_write !== 1'b1) begin fails++; $display("FAIL lk_release: got %b/%b want 1101/1", req_waitrequest, master_write); end
   endtask

   task automatic test_reset_in_drain();
      do_reset();
      req_read[1] = 1'b1;
      tick(); tick(); tick();
      req_read[1] = 1'b0;
      tick();
      rst_n = 1'b0;
      master_readdatavalid = 1'b1;
      @(negedge clk);
      checks++; if (req_waitrequest !== 4'hF || req_readdatavalid !== 4'h0) begin fails++; $display("FAIL rd_rst: got %b/%b want 1111/0000", req_waitrequest, req_readdatavalid); end
      checks++; if (master_read !== 1'b0 || master_address !== 32'h0) begin fails++; $display("FAIL rd_rst_bus: got %b/%h want 0/0", master_read, master_address); end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (req_readdatavalid !== 4'h0) begin fails++; $display("FAIL rd_stray: got %b want 0000", req_readdatavalid); end
      tick();
      master_readdatavalid = 1'b0;
      req_read[3] = 1'b1;
      tick();
      @(negedge clk);
      checks++; if (req_waitrequest !== 4'b0111 || master_read !== 1'b1) begin fails++; $display("FAIL rd_regrant: got %b/%b want 0111/1", req_waitrequest, master_read); end
   endtask

   task automatic test_random();
      int mode, owner, last, j;
      int q[$];
      bit g, full, found, e_read, e_write;
      logic [31:0] e_addr, e_wd;
      logic [N-1:0] e_wait, e_rdv;
      do_reset();
      mode = 0; owner = 0; last = N - 1;
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N; i++) begin
            req_read[i] = ($urandom_range(0, 3) != 0);
            req_write[i] = ($urandom_range(0, 7) == 0);
            req_address[32*i +: 32] = $urandom;
            req_writedata[32*i +: 32] = $urandom;
         end
         req_lock = N'($urandom);
         master_waitrequest = ($urandom_range(0, 3) == 0);
         master_readdatavalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         master_readdata = $urandom;
         g = (mode == 1);
         full = (q.size() == MO) && !master_readdatavalid;
         e_read = g && req_read[owner] && !full;
         e_write = g && req_write[owner];
         e_addr = g ? req_address[32*owner +: 32] : 32'h0;
         e_wd = g ? req_writedata[32*owner +: 32] : 32'h0;
         e_wait = '1;
         if (g) e_wait[owner] = master_waitrequest || full;
         e_rdv = '0;
         if (master_readdatavalid && q.size() > 0) e_rdv[q[0]] = 1'b1;
         @(negedge clk);
         checks++; if (master_read !== e_read) begin fails++; $display("FAIL rnd_mread c%0d: got %b want %b", c, master_read, e_read); end
         checks++; if (master_write !== e_write) begin fails++; $display("FAIL rnd_mwrite c%0d: got %b want %b", c, master_write, e_write); end
         checks++; if (master_address !== e_addr) begin fails++; $display("FAIL rnd_addr c%0d: got %h want %h", c, master_address, e_addr); end
         checks++; if (master_writedata !== e_wd) begin fails++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, master_writedata, e_wd); end
         checks++; if (req_waitrequest !== e_wait) begin fails++; $display("FAIL rnd_wait c%0d: got %b want %b", c, req_waitrequest, e_wait); end
         checks++; if (req_readdatavalid !== e_rdv) begin fails++; $display("FAIL rnd_rdv c%0d: got %b want %b", c, req_readdatavalid, e_rdv); end
         checks++; if (req_readdata !== master_readdata) begin fails++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, req_readdata, master_readdata); end
         if (master_readdatavalid && q.size() > 0) void'(q.pop_front());
         if (e_read && !master_waitrequest) q.push_back(owner);
         if (mode == 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
               j = (last + k) % N;
               if (!found && (req_read[j] || req_write[j])) begin found = 1'b1; owner = j; last = j; mode = 1; end
            end
         end else if (mode == 1) begin
            if (!(req_read[owner] || req_write[owner]) && !(LOCK && req_lock[owner])) mode = (q.size() == 0) ? 0 : 2;
         end else if (q.size() == 0) mode = 0;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_outstanding_limit();
      test_drain_switch();
      test_lock();
      test_reset_in_drain();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
